// File: rtl/db_gain_applier_if.sv
// Request/result bundle for db_gain_applier: the requester drives the start
// strobe with the sample and gain, the applier returns the scaled sample
// together with its done pulse and a busy flag.
interface db_gain_applier_if;
    logic               start;
    logic signed [11:0] input_sample;
    logic signed [8:0]  gain_db;
    logic signed [11:0] modified_sample;
    logic               done;
    logic               busy;

    modport master (
        output start,
        output input_sample,
        output gain_db,
        input  modified_sample,
        input  done,
        input  busy
    );

    modport slave (
        input  start,
        input  input_sample,
        input  gain_db,
        output modified_sample,
        output done,
        output busy
    );
endinterface

// File: rtl/db_gain_applier.sv
// Applies an integer-dB gain to one signed 12-bit sample.
// The clamped gain is split as g - GAIN_MIN_DB = 6*q + r by repeated
// subtraction. The linear gain is then 2^(q-8) * 10^(r/20): r selects a Q1.11
// mantissa and q selects the final rounding shift. The result is rounded
// (ties toward +inf) and saturated to the 12-bit range.
module db_gain_applier #(
    parameter int GAIN_MIN_DB = -48,
    parameter int GAIN_MAX_DB = 24
) (
    input  logic              clock,
    input  logic              reset,
    db_gain_applier_if.slave  bus
);
    localparam int DATA_W   = 12;
    localparam int COEF_W   = 13;  // Q1.11 mantissa plus sign bit
    localparam int PROD_W   = 24;
    localparam int ACC_W    = 25;  // headroom so the rounding bias cannot overflow
    localparam int FRAC_W   = 11;
    localparam int K_OFFSET = 8;   // k = q - K_OFFSET
    localparam int SPAN     = GAIN_MAX_DB - GAIN_MIN_DB;
    localparam int U_W      = $clog2(SPAN + 1);
    localparam int Q_W      = $clog2(SPAN / 6 + 1);

    typedef enum logic [1:0] {IDLE, DIV, MUL, SAT} state_t;

    state_t                     state;
    logic signed [DATA_W-1:0]   sample_p0;
    logic        [U_W-1:0]      rem;
    logic        [Q_W-1:0]      quo;
    logic signed [PROD_W-1:0]   product_p1;
    logic signed [DATA_W-1:0]   result;
    logic                       done_r;
    logic                       busy_r;

    // Clamp the requested gain and return its offset above the minimum.
    function automatic logic [U_W-1:0] clamp_gain(input logic signed [8:0] g);
        int gi;
        gi = int'(g);
        if (gi < GAIN_MIN_DB) gi = GAIN_MIN_DB;
        if (gi > GAIN_MAX_DB) gi = GAIN_MAX_DB;
        return U_W'(gi - GAIN_MIN_DB);
    endfunction

    // 10^(r/20) in Q1.11, for r = 0..5.
    function automatic logic signed [COEF_W-1:0] coef(input logic [2:0] r);
        case (r)
            3'd0:    return 13'sd2048;
            3'd1:    return 13'sd2298;
            3'd2:    return 13'sd2578;
            3'd3:    return 13'sd2893;
            3'd4:    return 13'sd3246;
            default: return 13'sd3642;
        endcase
    endfunction

    // Sample times mantissa. The magnitude never exceeds 2048*3642, so it fits in 24 bits.
    function automatic logic signed [PROD_W-1:0] mul_coef(
        input logic signed [DATA_W-1:0] s,
        input logic signed [COEF_W-1:0] c
    );
        logic signed [ACC_W-1:0] p;
        p = ACC_W'(s) * ACC_W'(c);
        return p[PROD_W-1:0];
    endfunction

    // Add half an LSB, then shift arithmetically. Ties resolve toward +inf.
    function automatic logic signed [ACC_W-1:0] round_shift(
        input logic signed [PROD_W-1:0] p,
        input logic        [4:0]        sh
    );
        logic signed [ACC_W-1:0] a;
        logic signed [ACC_W-1:0] bias;
        logic signed [ACC_W-1:0] sum;
        a    = ACC_W'(p);
        bias = ACC_W'(1) << (sh - 5'd1);
        sum  = a + bias;
        return sum >>> sh;
    endfunction

    // Clamp to the signed 12-bit output range.
    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] y);
        if (y > 25'sd2047)  return 12'sd2047;
        if (y < -25'sd2048) return -12'sd2048;
        return y[DATA_W-1:0];
    endfunction

    // Control FSM with divide, multiply and round/saturate steps; every output is registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            result     <= '0;
            sample_p0  <= '0;
            rem        <= '0;
            quo        <= '0;
            product_p1 <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sample_p0 <= bus.input_sample;
                        rem       <= clamp_gain(bus.gain_db);
                        quo       <= '0;
                        busy_r    <= 1'b1;
                        state     <= DIV;
                    end
                end
                DIV: begin
                    if (rem >= U_W'(6)) begin
                        rem <= rem - U_W'(6);
                        quo <= quo + Q_W'(1);
                    end else begin
                        state <= MUL;
                    end
                end
                MUL: begin
                    product_p1 <= mul_coef(sample_p0, coef(rem[2:0]));
                    state      <= SAT;
                end
                SAT: begin
                    result <= saturate(round_shift(product_p1,
                                       5'(FRAC_W + K_OFFSET) - 5'(quo)));
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.modified_sample = result;
    assign bus.done            = done_r;
    assign bus.busy            = busy_r;
endmodule

// File: tb/tb_db_gain_applier.sv
// Self-checking bench for db_gain_applier: a vector table with hand-derived
// results and latencies, a done-driven scoreboard, and hand-written handshake
// and reset sequences.
module tb_db_gain_applier;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    db_gain_applier_if bus();

    db_gain_applier #(.GAIN_MIN_DB(-48), .GAIN_MAX_DB(24)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int sample;
        int gain;
        int exp_out;
        int exp_lat;
    } vec_t;

    vec_t vecs[16];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   exp_q[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard: every done pops the oldest expected result.
    always @(negedge clock) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected done", 1, 0);
            end else begin
                chk($sformatf("result #%0d", done_cnt), int'(bus.modified_sample),
                    exp_q.pop_front());
            end
        end
    end

    task automatic drive_start(input int sample, input int gain);
        bus.start        = 1'b1;
        bus.input_sample = 12'(sample);
        bus.gain_db      = 9'(gain);
    endtask

    // Release start and scramble the inputs, which must no longer matter.
    task automatic release_start();
        bus.start        = 1'b0;
        bus.input_sample = 12'($urandom);
        bus.gain_db      = 9'($urandom);
    endtask

    // Count cycles after the start-sampling edge until done is seen; -1 on timeout.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clock); #1;
            if (bus.done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input int idx);
        int n;
        @(posedge clock); #1;
        drive_start(vecs[idx].sample, vecs[idx].gain);
        exp_q.push_back(vecs[idx].exp_out);
        @(posedge clock); #1;
        release_start();
        chk($sformatf("v%0d busy after start", idx), int'(bus.busy), 1);
        wait_done(n);
        chk($sformatf("v%0d latency", idx), n, vecs[idx].exp_lat);
        chk($sformatf("v%0d busy in done cycle", idx), int'(bus.busy), 0);
        @(posedge clock); #1;
        chk($sformatf("v%0d done one cycle", idx), int'(bus.done), 0);
        chk($sformatf("v%0d result held", idx), int'(bus.modified_sample), vecs[idx].exp_out);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;

        vecs[0]  = '{1000,     0,  1000, 11};
        vecs[1]  = '{1000,     6,  2000, 12};
        vecs[2]  = '{1000,     3,  1413, 11};
        vecs[3]  = '{1000,    24,  2047, 15};
        vecs[4]  = '{-2048,    6, -2048, 12};
        vecs[5]  = '{1000,   100,  2047, 15};
        vecs[6]  = '{1000,   -48,     4,  3};
        vecs[7]  = '{-1000,  -48,    -4,  3};
        vecs[8]  = '{1,        0,     1, 11};
        vecs[9]  = '{1000,  -100,     4,  3};
        vecs[10] = '{-1000,   -6,  -500, 10};
        vecs[11] = '{500,     -1,   445, 10};
        vecs[12] = '{-2048,   24, -2048, 15};
        vecs[13] = '{2047,   -43,    14,  3};
        vecs[14] = '{1,       -6,     1, 10};
        vecs[15] = '{-1,      -6,     0, 10};

        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.input_sample = '0;
        bus.gain_db      = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset done", int'(bus.done), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset modified_sample", int'(bus.modified_sample), 0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(i);

        // A second start while busy is ignored.
        d0 = done_cnt;
        @(posedge clock); #1;
        drive_start(1000, 0);
        exp_q.push_back(1000);
        @(posedge clock); #1;
        release_start();
        @(posedge clock); #1;
        drive_start(500, 24);
        @(posedge clock); #1;
        release_start();
        @(posedge clock); #1;
        drive_start(-700, 12);
        @(posedge clock); #1;
        release_start();
        wait_done(n);
        chk("busy-ignore latency", n, 7);
        repeat (20) @(posedge clock);
        #1;
        chk("busy-ignore done count", done_cnt - d0, 1);
        chk("busy-ignore busy idle", int'(bus.busy), 0);

        // A start in the done cycle is accepted back to back.
        @(posedge clock); #1;
        drive_start(1000, 6);
        exp_q.push_back(2000);
        @(posedge clock); #1;
        release_start();
        wait_done(n);
        chk("b2b first latency", n, 12);
        drive_start(-1000, -48);
        exp_q.push_back(-4);
        @(posedge clock); #1;
        release_start();
        chk("b2b second busy", int'(bus.busy), 1);
        wait_done(n);
        chk("b2b second latency", n, 3);
        @(posedge clock); #1;

        // Reset during DIV of a +24 dB request discards it.
        drive_start(1000, 24);
        @(posedge clock); #1;
        release_start();
        repeat (4) @(posedge clock);
        #2;
        chk("pre-reset busy", int'(bus.busy), 1);
        reset = 1'b1;
        #1;
        chk("midreset done", int'(bus.done), 0);
        chk("midreset busy", int'(bus.busy), 0);
        chk("midreset modified_sample", int'(bus.modified_sample), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        d0 = done_cnt;
        repeat (20) @(posedge clock);
        #1;
        chk("no done after reset", done_cnt - d0, 0);
        run_vec(2);

        chk("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/db_gain_applier.md
# db_gain_applier

Converts a signed integer-dB gain into a linear multiplier and applies it to one signed 12-bit audio sample, with rounding and saturation. It is the inverse path of the sample-to-dB / gain-computer chain in the compression stage: it takes the computed gain in dB and produces the gain-adjusted output sample. It uses a start/done handshake and processes one sample per request. It fits easily within a 24 kHz sample period.

## Interface
Parameters:
- GAIN_MIN_DB, -48: lowest accepted gain; gain_db below this is clamped to it.
- GAIN_MAX_DB, 24: highest accepted gain; gain_db above this is clamped to it.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- start  input  1  single-cycle request; sampled only in IDLE.
- input_sample  input  12  signed sample to scale.
- gain_db  input  9  signed gain in whole dB.
- modified_sample  output  12  signed scaled result; holds its value until the next done.
- done  output  1  one-cycle pulse; modified_sample is valid in this cycle.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, DIV, MUL, SAT.
- IDLE, start=1:
  - Latch input_sample.
  - Clamp gain_db to [GAIN_MIN_DB, GAIN_MAX_DB], then compute u = g − GAIN_MIN_DB (0..72).
  - Set rem = u and q = 0, then go to DIV.
- DIV: sequential divide by 6.
  - If rem ≥ 6: rem −= 6, q += 1, stay in DIV.
  - Otherwise: go to MUL.
  - Results: r = rem (0..5), k = q − 8 (−8..+4). With the default parameters, gain = 2^k · 10^(r/20) ≈ 10^(g/20).
- MUL: product = sample × M[r], where M is a Q1.11 table:
  - Values: 2048, 2298, 2578, 2893, 3246, 3642.
  - Product is a signed 24-bit value; store it, then go to SAT.
- SAT:
  - s = 11 − k (range 7..19).
  - y = (product + 2^(s−1)) >>> s, using an arithmetic shift; ties round toward +∞.
  - Clamp y to [−2048, 2047] and register the result into modified_sample.
  - Assert done, then go to IDLE.
- Internal widths: rounding and shift are done in at least 25 bits so that rounding cannot overflow.
- start while busy=1 is ignored (no queuing). start in the same cycle that done is high is accepted, because the FSM is already in IDLE.
- Changes to input_sample or gain_db after start is accepted have no effect on the current operation.

## Timing
- Reset values: modified_sample = 0, done = 0, busy = 0, state = IDLE. The asynchronous reset takes effect immediately, including mid-operation; the in-flight result is discarded and no done is issued.
- Cycle count from the start-sampling edge E0:
  - DIV occupies q+1 edges.
  - MUL takes 1 edge; SAT takes 1 edge.
  - done is high for exactly one cycle following edge E0+q+3.
- Latency is q+3 cycles: minimum 3 (g = −48..−43), maximum 15 (g = +24).
- busy rises after E0 and falls on the same edge that raises done.
- At most one done per accepted start; done is never asserted without a preceding accepted start.

## Test plan
- Unity gain: sample=1000, gain_db=0 → q=8, r=0; modified_sample=1000; done exactly 11 cycles after start.
- +6 dB and fractional step:
  - sample=1000, gain=+6 → 2000 after 12 cycles.
  - sample=1000, gain=+3 → 1413 after 11 cycles.
- Saturation and clamping:
  - sample=1000, gain=+24 → 2047 after 15 cycles.
  - sample=−2048, gain=+6 → −2048.
  - gain_db=+100 behaves identically to +24.
  - gain_db=−100 behaves identically to −48.
- Minimum gain and rounding:
  - sample=1000, gain=−48 → 4 after 3 cycles.
  - sample=−1000, gain=−48 → −4.
  - sample=1, gain=0 → 1.
- Handshake:
  - A second start pulse during busy is ignored: one done only, with the first result.
  - start asserted in the done cycle is accepted; a back-to-back second result follows with correct latency.
- Reset mid-operation: assert reset during DIV of a +24 dB request →
  - done, busy and modified_sample go to 0 immediately;
  - no done appears after reset is released;
  - a subsequent request completes normally.
